serial_adder: RTL and testbench

//  Parametrised multi-cycle adder; successor to the single-bit half adder.

---
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands DIGIT bits per clock, LSB digit first.
// Optional subtract mode is enabled with `define SERIAL_ADDER_SUB_EN (adds a 'sub' port).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // state  | meaning
    // S_IDLE | no result yet, waiting for start
    // S_RUN  | processing one digit per cycle
    // S_DONE | sum/carry hold a completed result; start relaunches
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               cr_q, cr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic               sub_in;
    logic               load;
    logic               last;
    logic [DIGIT:0]     digit_res;
    logic [WIDTH-1:0]   acc_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign load = start && (state_q != S_RUN);
    assign last = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_RUN);
        out_valid = (state_q == S_DONE);
    end

    // Operands shift right each cycle; each digit sum enters the accumulator at the top,
    // so after N cycles the accumulator holds the full sum in place.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cr_d      = cr_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        digit_res = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(cr_q);
        acc_next  = (acc_q >> DIGIT) | (WIDTH'(digit_res[DIGIT-1:0]) << (WIDTH - DIGIT));
        if (load) begin
            a_d   = in_1;
            b_d   = sub_in ? ~in_2 : in_2;
            acc_d = '0;
            cr_d  = sub_in;
            cnt_d = CNT_W'(N - 1);
        end else if (state_q == S_RUN) begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            acc_d = acc_next;
            cr_d  = digit_res[DIGIT];
            if (last) begin
                sum_d   = acc_next;
                carry_d = digit_res[DIGIT];
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cr_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cr_q    <= cr_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (DIGIT = 1, 4, 8) at WIDTH = 8.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start_v [3];
    logic [7:0] in1_v   [3];
    logic [7:0] in2_v   [3];
    logic       busy_v  [3];
    logic       ov_v    [3];
    logic [7:0] sum_v   [3];
    logic       carry_v [3];
    logic       sub_s;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q [$];
    int nexp_v [3] = '{8, 2, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .in_1(in1_v[0]), .in_2(in2_v[0]), .busy(busy_v[0]), .out_valid(ov_v[0]),
        .sum(sum_v[0]), .carry(carry_v[0]));

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .in_1(in1_v[1]), .in_2(in2_v[1]), .busy(busy_v[1]), .out_valid(ov_v[1]),
        .sum(sum_v[1]), .carry(carry_v[1]));

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .in_1(in1_v[2]), .in_2(in2_v[2]), .busy(busy_v[2]), .out_valid(ov_v[2]),
        .sum(sum_v[2]), .carry(carry_v[2]));

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [8:0] r;
        if (s) r = {(a >= b), 8'(a - b)};
        else   r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    // Drives a one-cycle start at a negedge and records the expected result; returns at the
    // negedge right after the accepting edge.
    task automatic launch(input int sel, input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        start_v[sel] = 1'b1;
        in1_v[sel]   = a;
        in2_v[sel]   = b;
        sub_s        = s;
        exp_q.push_back(model(a, b, s));
        @(negedge clk);
        start_v[sel] = 1'b0;
        in1_v[sel]   = 8'($urandom);
        in2_v[sel]   = 8'($urandom);
    endtask

    // Counts busy cycles (sampled at negedges) until out_valid, bounded.
    task automatic wait_done(input int sel, output int nbusy, output logic tmo);
        nbusy = 0;
        tmo   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (ov_v[sel]) begin
                tmo = 1'b0;
                break;
            end
            if (busy_v[sel]) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            total++;
            if (busy_v[s] !== 1'b0 || ov_v[s] !== 1'b0 || sum_v[s] !== 8'h00 || carry_v[s] !== 1'b0) begin
                bad++;
                $display("FAIL reset[%0d]: got busy=%b ov=%b sum=%h c=%b want 0 0 00 0",
                         s, busy_v[s], ov_v[s], sum_v[s], carry_v[s]);
            end
        end
    endtask

    task automatic test_add(input int sel, input logic [7:0] a, input logic [7:0] b, input logic s);
        int nb;
        logic tmo;
        logic [8:0] e;
        launch(sel, a, b, s);
        wait_done(sel, nb, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo) begin
            bad++;
            $display("FAIL add_timeout[%0d] %h,%h: out_valid never rose", sel, a, b);
        end else if ({carry_v[sel], sum_v[sel]} !== e) begin
            bad++;
            $display("FAIL add[%0d] %h,%h sub=%b: got c=%b sum=%h want c=%b sum=%h",
                     sel, a, b, s, carry_v[sel], sum_v[sel], e[8], e[7:0]);
        end
        total++;
        if (nb != nexp_v[sel]) begin
            bad++;
            $display("FAIL busy_len[%0d]: got %0d want %0d", sel, nb, nexp_v[sel]);
        end
    endtask

    task automatic test_hold();
        logic [8:0] e;
        test_add(0, 8'h5A, 8'h3C, 1'b0);
        e = {carry_v[0], sum_v[0]};
        repeat (4) @(negedge clk);
        total++;
        if (ov_v[0] !== 1'b1 || {carry_v[0], sum_v[0]} !== 9'h096) begin
            bad++;
            $display("FAIL hold: got ov=%b c=%b sum=%h want ov=1 c=0 sum=96 (was %h)",
                     ov_v[0], carry_v[0], sum_v[0], e);
        end
    endtask

    task automatic test_ignore_start();
        int nb;
        logic tmo;
        logic [8:0] e;
        launch(0, 8'h01, 8'h02, 1'b0);
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1;
        in1_v[0]   = 8'hAA;
        in2_v[0]   = 8'h55;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, nb, tmo);
        e = exp_q.pop_front();
        total++;
        if (tmo || {carry_v[0], sum_v[0]} !== e) begin
            bad++;
            $display("FAIL ignore: tmo=%b got c=%b sum=%h want c=%b sum=%h",
                     tmo, carry_v[0], sum_v[0], e[8], e[7:0]);
        end
        total++;
        if (nb != 5) begin
            bad++;
            $display("FAIL ignore_len: got %0d busy cycles after pulse, want 5", nb);
        end
        repeat (10) @(negedge clk);
        total++;
        if (ov_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL ignore_relaunch: got ov=%b busy=%b want 1 0", ov_v[0], busy_v[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        launch(0, 8'h80, 8'h80, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        total++;
        if (busy_v[0] !== 1'b0 || ov_v[0] !== 1'b0 || sum_v[0] !== 8'h00 || carry_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL abort: got busy=%b ov=%b sum=%h c=%b want 0 0 00 0",
                     busy_v[0], ov_v[0], sum_v[0], carry_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_add(0, 8'h80, 8'h80, 1'b0);
    endtask

    task automatic test_back_to_back();
        int nb;
        logic tmo;
        logic [8:0] e;
        logic [7:0] a_t [4] = '{8'h11, 8'hF0, 8'h7F, 8'hC3};
        logic [7:0] b_t [4] = '{8'h22, 8'h20, 8'h01, 8'h3D};
        @(negedge clk);
        start_v[0] = 1'b1;
        in1_v[0]   = a_t[0];
        in2_v[0]   = b_t[0];
        exp_q.push_back(model(a_t[0], b_t[0], 1'b0));
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            wait_done(0, nb, tmo);
            e = exp_q.pop_front();
            total++;
            if (tmo || {carry_v[0], sum_v[0]} !== e || nb != 8) begin
                bad++;
                $display("FAIL b2b[%0d]: tmo=%b busy=%0d got c=%b sum=%h want busy=8 c=%b sum=%h",
                         k, tmo, nb, carry_v[0], sum_v[0], e[8], e[7:0]);
            end
            if (k < 3) begin
                in1_v[0] = a_t[k+1];
                in2_v[0] = b_t[k+1];
                exp_q.push_back(model(a_t[k+1], b_t[k+1], 1'b0));
            end else begin
                start_v[0] = 1'b0;
            end
            @(negedge clk);
            if (k < 3) begin
                total++;
                if (busy_v[0] !== 1'b1 || ov_v[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_relaunch[%0d]: got busy=%b ov=%b want 1 0", k, busy_v[0], ov_v[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            test_add(k % 3, 8'($urandom), 8'($urandom), 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sub_s = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start_v[s] = 1'b0;
            in1_v[s]   = 8'h00;
            in2_v[s]   = 8'h00;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_hold();
        test_add(0, 8'hFF, 8'h01, 1'b0);
        test_add(1, 8'hFF, 8'hFF, 1'b0);
        test_add(2, 8'hFF, 8'hFF, 1'b0);
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
`ifdef SERIAL_ADDER_SUB_EN
        test_add(0, 8'h10, 8'h20, 1'b1);
        test_add(0, 8'h20, 8'h10, 1'b1);
        test_add(1, 8'h33, 8'h33, 1'b1);
        test_add(2, 8'h05, 8'hF0, 1'b1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
